// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizing and state encoding for the 8:1 mux round-robin arbiter.
//   N_REQ    requesters (fixed to the external 8:1 mux)
//   SEL_W    mux select width
//   DATA_W   mux data width
//   HOLD_MAX max OWN cycles per grant (only with ARB_TIMEOUT_EN)
package mux_arb_pkg;
  localparam int N_REQ    = 8;
  localparam int SEL_W    = 3;
  localparam int DATA_W   = 4;
  localparam int HOLD_MAX = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin pick.
//   req    [N_REQ-1:0] request vector
//   ptr    [SEL_W-1:0] last served index (lowest priority)
//   winner [SEL_W-1:0] first set req bit scanning ptr+1, ptr+2, ... mod N_REQ
//   any                at least one req bit set
// Rotate so ptr+1 lands at bit 0, priority-encode the lowest bit, un-rotate.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);
  logic [SEL_W-1:0] w_base;
  logic [N_REQ-1:0] w_rot;
  logic [SEL_W-1:0] w_idx;

  assign w_base = ptr + 1'b1;

  // Index arithmetic is SEL_W wide, so the sum wraps mod N_REQ for free.
  for (genvar g = 0; g < N_REQ; g++) begin : g_rot
    assign w_rot[g] = req[SEL_W'(g) + w_base];
  end

  // Descending scan: the last assignment is the lowest set bit.
  always_comb begin
    w_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_idx = SEL_W'(i);
    end
  end

  assign winner = w_idx + w_base;
  assign any    = |req;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of the external 8:1 4-bit mux select.
//   clk, rst_n      clock, async active-low reset
//   req, done       per-requester request level / last-beat flag (owner only)
//   gnt, sel        registered one-hot grant and mux select
//   busy            high while a requester owns the mux
//   d_in            mux output fed back
//   q_out, q_valid  registered data beat, one-cycle valid per captured beat
//   timeout         one-cycle pulse on forced release
// Optional: define ARB_TIMEOUT_EN to force release after HOLD_MAX OWN cycles;
// without it timeout is tied 0 and a grant is held indefinitely.
module mux_rr_arbiter
  import mux_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  done,
  output logic [N_REQ-1:0]  gnt,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] q_out,
  output logic              q_valid,
  output logic              timeout
);
  state_e            r_state, w_state_n;
  logic [N_REQ-1:0]  r_gnt,   w_gnt_n;
  logic [SEL_W-1:0]  r_sel,   w_sel_n;
  logic [SEL_W-1:0]  r_ptr,   w_ptr_n;
  logic [DATA_W-1:0] r_q,     w_q_n;
  logic              r_qv,    w_qv_n;
  logic              r_to,    w_to_n;
  logic [SEL_W-1:0]  w_win;
  logic              w_any;
  logic [N_REQ-1:0]  w_onehot;
  logic              w_own_req, w_own_done, w_nat_rel;
`ifdef ARB_TIMEOUT_EN
  logic [3:0]        r_hold,  w_hold_n;
`endif

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_win),
    .any    (w_any)
  );

  assign w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
  // sel always names the owner while busy, so it indexes the owner's bits.
  assign w_own_req  = req[r_sel];
  assign w_own_done = done[r_sel];
  assign w_nat_rel  = !w_own_req || w_own_done;

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_sel_n   = r_sel;
    w_ptr_n   = r_ptr;
    w_q_n     = r_q;
    w_qv_n    = 1'b0;
    w_to_n    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_hold_n  = r_hold;
`endif
    case (r_state)
      ST_IDLE: begin
        w_gnt_n = '0;
        if (w_any) begin
          w_gnt_n   = w_onehot;
          w_sel_n   = w_win;
          w_state_n = ST_OWN;
`ifdef ARB_TIMEOUT_EN
          w_hold_n  = '0;
`endif
        end
      end
      ST_OWN: begin
        if (w_own_req) begin
          w_q_n  = d_in;
          w_qv_n = 1'b1;
        end
        // Release always goes through IDLE, giving the one-cycle turnaround.
        if (w_nat_rel) begin
          w_gnt_n   = '0;
          w_ptr_n   = r_sel;
          w_state_n = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_hold == 4'(HOLD_MAX - 1)) begin
          w_gnt_n   = '0;
          w_ptr_n   = r_sel;
          w_state_n = ST_IDLE;
          w_to_n    = 1'b1;
        end else begin
          w_hold_n  = r_hold + 4'd1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= SEL_W'(N_REQ - 1);
      r_q     <= '0;
      r_qv    <= 1'b0;
      r_to    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold  <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_sel   <= w_sel_n;
      r_ptr   <= w_ptr_n;
      r_q     <= w_q_n;
      r_qv    <= w_qv_n;
      r_to    <= w_to_n;
`ifdef ARB_TIMEOUT_EN
      r_hold  <= w_hold_n;
`endif
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = (r_state == ST_OWN);
  assign q_out   = r_q;
  assign q_valid = r_qv;
  assign timeout = r_to;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0, done = '0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy, q_valid, timeout;
  logic [3:0] d_in = '0, q_out;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt(gnt), .sel(sel),
    .busy(busy), .d_in(d_in), .q_out(q_out), .q_valid(q_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_owner = -1;   // -1 = nobody owns the mux
  int         m_ptr   = 7;
  int         m_sel   = 0;
  logic [3:0] m_q     = '0;
  logic       m_qv    = 1'b0;
  logic       m_to    = 1'b0;
  int         m_hold  = 0;

  function automatic int scan(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_ptr <= 7; m_sel <= 0; m_q <= '0;
      m_qv <= 1'b0; m_to <= 1'b0; m_hold <= 0;
    end else if (m_owner < 0) begin
      m_qv <= 1'b0; m_to <= 1'b0;
      if (req != 8'h00) begin
        m_owner <= scan(req, m_ptr);
        m_sel   <= scan(req, m_ptr);
        m_hold  <= 0;
      end
    end else begin
      m_qv <= req[m_owner];
      if (req[m_owner]) m_q <= d_in;
      m_to <= 1'b0;
      if (!req[m_owner] || done[m_owner]) begin
        m_owner <= -1; m_ptr <= m_owner;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_hold == HOLD_MAX - 1) begin
        m_owner <= -1; m_ptr <= m_owner; m_to <= 1'b1;
      end else m_hold <= m_hold + 1;
`endif
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    chk("gnt",     32'(gnt),     (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
    chk("sel",     32'(sel),     32'(m_sel));
    chk("busy",    32'(busy),    32'(m_owner >= 0));
    chk("q_valid", 32'(q_valid), 32'(m_qv));
    if (m_qv) chk("q_out", 32'(q_out), 32'(m_q));
    chk("timeout", 32'(timeout), 32'(m_to));
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] seen[$];

  initial begin
    // Reset state
    step(2);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_q_out", 32'(q_out), 32'h0);
    chk("rst_q_valid", 32'(q_valid), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;

    // Single 1-beat transfer on requester 0
    req = 8'h01;
    step();
    chk("t1_gnt", 32'(gnt), 32'h01);
    chk("t1_sel", 32'(sel), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    done = 8'h01; d_in = 4'hA;
    step();
    chk("t1_q_out", 32'(q_out), 32'hA);
    chk("t1_q_valid", 32'(q_valid), 32'h1);
    chk("t1_gnt_rel", 32'(gnt), 32'h0);
    req = 8'h00; done = 8'h00;
    step();
    chk("t1_q_valid_drop", 32'(q_valid), 32'h0);
    chk("t1_q_hold", 32'(q_out), 32'hA);

    // Fresh reset, all requesting, each done on first OWN cycle
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 8'hFF; done = 8'hFF;
    for (int k = 0; k < 17; k++) begin
      d_in = 4'(k);
      step();
      seen.push_back(gnt);
    end
    for (int k = 0; k < 17; k++)
      chk("rr_order", 32'(seen[k]), (k % 2 == 0) ? (32'h1 << ((k / 2) % 8)) : 32'h0);

    // Owner 0 now; abort, then serve 3 to set ptr=3
    req = 8'h00; done = 8'h00;
    step(2);
    req = 8'h08;
    step();
    chk("s3_gnt", 32'(gnt), 32'h08);
    done = 8'h08;
    step();
    // ptr=3: req 0 and 3 -> scan 4..7,0 picks 0
    req = 8'h09; done = 8'h00;
    step();
    chk("p3_gnt", 32'(gnt), 32'h01);
    chk("p3_sel", 32'(sel), 32'h0);

    // Release 0, then requester 5 aborts mid-transfer with 2 pending
    done = 8'h01;
    step();
    req = 8'h20; done = 8'h00;
    step();
    chk("a5_gnt", 32'(gnt), 32'h20);
    d_in = 4'h3;
    step();
    chk("a5_q_out", 32'(q_out), 32'h3);
    chk("a5_q_valid", 32'(q_valid), 32'h1);
    req = 8'h04; d_in = 4'h9;
    step();
    chk("a5_gnt_rel", 32'(gnt), 32'h0);
    chk("a5_q_valid0", 32'(q_valid), 32'h0);
    chk("a5_q_keep", 32'(q_out), 32'h3);
    step();
    chk("a5_next", 32'(gnt), 32'h04);
    chk("a5_next_sel", 32'(sel), 32'h2);

    // Async reset while requester 4 owns the mux
    done = 8'h04;
    step();
    req = 8'h10; done = 8'h00;
    step();
    chk("r4_gnt", 32'(gnt), 32'h10);
    req = 8'h11;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_sel", 32'(sel), 32'h0);
    chk("ar_q_valid", 32'(q_valid), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_first", 32'(gnt), 32'h01);

    // Abort 0 (ptr=0), then grant 2 and hold it with no done
    req = 8'h00;
    step(2);
    req = 8'h04;
    step();
    chk("h2_gnt", 32'(gnt), 32'h04);
    req = 8'h0C;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k < HOLD_MAX; k++) begin
      d_in = 4'(k);
      step();
      chk("to_hold_busy", 32'(busy), 32'h1);
      chk("to_hold_pulse", 32'(timeout), 32'h0);
    end
    d_in = 4'h7;
    step();
    chk("to_gnt", 32'(gnt), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    chk("to_q_valid", 32'(q_valid), 32'h1);
    chk("to_q_out", 32'(q_out), 32'h7);
    step();
    chk("to_next", 32'(gnt), 32'h08);
    chk("to_pulse_end", 32'(timeout), 32'h0);
`else
    for (int k = 0; k < 20; k++) begin
      d_in = 4'(k);
      step();
      chk("nt_hold", 32'(gnt), 32'h04);
      chk("nt_timeout", 32'(timeout), 32'h0);
    end
    req = 8'h08;
    step();
    chk("nt_abort", 32'(gnt), 32'h0);
    step();
    chk("nt_next", 32'(gnt), 32'h08);
`endif
    req = 8'h00; done = 8'h00;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
